// File: rtl/nx_fifo_pkt_drain.sv
`default_nettype none
// ============================================================================
//  Module      : nx_fifo_pkt_drain
//  Description : Drains an nx_fifo into a registered valid/ready stream using
//                a 2-entry skid buffer. Packets longer than MAX_BEATS are cut
//                with a forced last, and the rest of the packet is discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module nx_fifo_pkt_drain #(
    parameter int WIDTH     = 71,
    parameter int MAX_BEATS = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-2:0] out_data,
    output logic             out_last,
    output logic             out_trunc,
    output logic             trunc_pulse,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    localparam int                c_BC_W    = $clog2(MAX_BEATS);
    localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(MAX_BEATS - 1);
    localparam logic [0:0]        c_ST_PASS = 1'b0;
    localparam logic [0:0]        c_ST_DROP = 1'b1;

    logic [0:0]        r_state;
    logic [1:0]        r_occ;
    logic [WIDTH-2:0]  r_head_data;
    logic              r_head_last;
    logic              r_head_trunc;
    logic [WIDTH-2:0]  r_tail_data;
    logic              r_tail_last;
    logic              r_tail_trunc;
    logic [c_BC_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0]  r_pkt_count;
    logic [CNT_W-1:0]  r_drop_count;
    logic              r_trunc_pulse;

    logic w_ren;
    logic w_eop;
    logic w_pass_pop;
    logic w_drop_pop;
    logic w_at_max;
    logic w_new_last;
    logic w_new_trunc;
    logic w_cut;
    logic w_deq;

    // Pop permission depends only on registered state, never on out_ready.
    assign w_ren       = !fifo_empty && !clear && ((r_state == c_ST_DROP) || (r_occ != 2'd2));
    assign w_eop       = fifo_rdata[WIDTH-1];
    assign w_pass_pop  = w_ren && (r_state == c_ST_PASS);
    assign w_drop_pop  = w_ren && (r_state == c_ST_DROP);
    assign w_at_max    = (r_beat_cnt == c_BC_LAST);
    assign w_new_last  = w_eop || w_at_max;
    assign w_new_trunc = !w_eop && w_at_max;
    assign w_cut       = w_pass_pop && w_new_trunc;
    assign w_deq       = (r_occ != 2'd0) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ        <= 2'd0;
            r_head_data  <= '0;
            r_head_last  <= 1'b0;
            r_head_trunc <= 1'b0;
            r_tail_data  <= '0;
            r_tail_last  <= 1'b0;
            r_tail_trunc <= 1'b0;
        end else if (clear) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_pass_pop, w_deq})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_data  <= fifo_rdata[WIDTH-2:0];
                        r_head_last  <= w_new_last;
                        r_head_trunc <= w_new_trunc;
                    end else begin
                        r_tail_data  <= fifo_rdata[WIDTH-2:0];
                        r_tail_last  <= w_new_last;
                        r_tail_trunc <= w_new_trunc;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head_data  <= r_tail_data;
                    r_head_last  <= r_tail_last;
                    r_head_trunc <= r_tail_trunc;
                    r_occ        <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head_data  <= fifo_rdata[WIDTH-2:0];
                        r_head_last  <= w_new_last;
                        r_head_trunc <= w_new_trunc;
                    end else begin
                        r_head_data  <= r_tail_data;
                        r_head_last  <= r_tail_last;
                        r_head_trunc <= r_tail_trunc;
                        r_tail_data  <= fifo_rdata[WIDTH-2:0];
                        r_tail_last  <= w_new_last;
                        r_tail_trunc <= w_new_trunc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_PASS;
            r_beat_cnt    <= '0;
            r_pkt_count   <= '0;
            r_drop_count  <= '0;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_trunc_pulse <= w_cut;
            if (w_pass_pop && w_new_last && (r_pkt_count != {CNT_W{1'b1}})) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_drop_pop && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
            if (clear) begin
                r_state    <= c_ST_PASS;
                r_beat_cnt <= '0;
            end else if (w_pass_pop) begin
                r_beat_cnt <= w_new_last ? '0 : r_beat_cnt + 1'b1;
                if (w_cut) begin
                    r_state <= c_ST_DROP;
                end
            end else if (w_drop_pop && w_eop) begin
                r_state <= c_ST_PASS;
            end
        end
    end

    assign fifo_ren    = w_ren;
    assign out_valid   = (r_occ != 2'd0);
    assign out_data    = r_head_data;
    assign out_last    = r_head_last;
    assign out_trunc   = r_head_trunc;
    assign trunc_pulse = r_trunc_pulse;
    assign pkt_count   = r_pkt_count;
    assign drop_count  = r_drop_count;
    assign busy        = (r_occ != 2'd0) || (r_state == c_ST_DROP);

endmodule
`default_nettype wire

// File: tb/tb_nx_fifo_pkt_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nx_fifo_pkt_drain
//  Description : Scoreboard bench for nx_fifo_pkt_drain with a packet-level
//                expectation model and a FIFO source model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nx_fifo_pkt_drain;

    localparam int W  = 71;
    localparam int MB = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [W-2:0] d;
        logic         last;
        logic         trunc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rdata;
    logic          fifo_ren;
    logic          out_valid;
    logic          out_ready;
    logic [W-2:0]  out_data;
    logic          out_last;
    logic          out_trunc;
    logic          trunc_pulse;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] drop_count;
    logic          busy;

    logic [W-1:0] src_q[$];
    logic [W-1:0] pkt[$];
    beat_t        exp_q[$];
    int           beat_cyc[$];

    int n_chk = 0;
    int n_fail = 0;
    int pops = 0;
    int tp_seen = 0;
    int cyc = 0;
    int pkts_exp = 0;
    int drops_exp = 0;
    int truncs_exp = 0;
    bit gate = 1'b0;
    bit mon_en = 1'b0;

    nx_fifo_pkt_drain #(.WIDTH(W), .MAX_BEATS(MB), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_ren    (fifo_ren),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_trunc   (out_trunc),
        .trunc_pulse (trunc_pulse),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [W-2:0] rand_pl();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[W-2:0];
    endfunction

    function automatic void build_pkt(int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back({(i == len - 1), rand_pl()});
    endfunction

    // A packet of n words yields min(n, MB) beats; longer packets end in a forced last.
    function automatic void expect_pkt();
        int    n;
        int    k;
        beat_t b;
        n = pkt.size();
        k = (n < MB) ? n : MB;
        for (int i = 0; i < k; i++) begin
            b.d     = pkt[i][W-2:0];
            b.last  = (i == k - 1);
            b.trunc = (i == k - 1) && (n > MB);
            exp_q.push_back(b);
        end
        pkts_exp++;
        if (n > MB) begin
            drops_exp += n - MB;
            truncs_exp++;
        end
    endfunction

    function automatic void send_pkt(int len);
        build_pkt(len);
        expect_pkt();
        foreach (pkt[i]) src_q.push_back(pkt[i]);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(string name, int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0 || busy) && i < budget) begin
            step();
            i++;
        end
        chk(name, W'(i < budget), W'(1));
    endtask

    // FIFO source: head word is visible combinationally, popped on fifo_ren.
    initial begin
        bit ren_s;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        forever begin
            @(negedge clk);
            ren_s = fifo_ren;
            if (fifo_ren) chk("pop_when_empty", W'(fifo_empty), W'(0));
            @(posedge clk);
            #1;
            if (ren_s && src_q.size() != 0) begin
                void'(src_q.pop_front());
                pops++;
            end
            fifo_empty = gate || (src_q.size() == 0);
            fifo_rdata = fifo_empty ? '0 : src_q[0];
        end
    end

    // Monitor: compares every delivered beat against the scoreboard.
    initial begin
        beat_t        e;
        bit           prev_stall;
        logic [W-2:0] prev_d;
        prev_stall = 1'b0;
        prev_d     = '0;
        forever begin
            @(negedge clk);
            if (trunc_pulse) tp_seen++;
            if (mon_en) begin
                if (prev_stall) begin
                    chk("valid_held", W'(out_valid), W'(1));
                    chk("data_held", W'(out_data), W'(prev_d));
                end
                if (out_valid && out_ready) begin
                    beat_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", W'(1), W'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", W'(out_data), W'(e.d));
                        chk("out_last", W'(out_last), W'(e.last));
                        chk("out_trunc", W'(out_trunc), W'(e.trunc));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int p0;
        int tp0;
        int pc;
        int words;
        int i;
        rst       = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_fifo_ren", W'(fifo_ren), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_pkt_count", W'(pkt_count), W'(0));
        chk("rst_drop_count", W'(drop_count), W'(0));
        chk("rst_trunc_pulse", W'(trunc_pulse), W'(0));
        chk("rst_out_data", W'(out_data), W'(0));
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        // Short packet streams back-to-back.
        out_ready = 1'b1;
        base = beat_cyc.size();
        send_pkt(3);
        wait_drain("t1_drain", 50);
        chk("t1_beats", W'(beat_cyc.size() - base), W'(3));
        if (beat_cyc.size() - base == 3) chk("t1_consecutive", W'(beat_cyc[base+2] - beat_cyc[base]), W'(2));
        chk("t1_pkt_count", W'(pkt_count), W'(1));

        // Backpressure fills the skid buffer, then drains without bubbles.
        out_ready = 1'b0;
        p0 = pops;
        send_pkt(3);
        send_pkt(2);
        repeat (8) step();
        chk("t2_pops_stalled", W'(pops - p0), W'(2));
        chk("t2_ren_stalled", W'(fifo_ren), W'(0));
        chk("t2_valid_stalled", W'(out_valid), W'(1));
        base = beat_cyc.size();
        out_ready = 1'b1;
        wait_drain("t2_drain", 50);
        chk("t2_beats", W'(beat_cyc.size() - base), W'(5));
        if (beat_cyc.size() - base == 5) chk("t2_no_bubble", W'(beat_cyc[base+4] - beat_cyc[base]), W'(4));

        // Over-long packet truncation, followed by a normal packet.
        tp0 = tp_seen;
        send_pkt(7);
        send_pkt(2);
        wait_drain("t3_drain", 80);
        chk("t3_drop_count", W'(drop_count), W'(3));
        chk("t3_trunc_pulses", W'(tp_seen - tp0), W'(1));
        chk("t3_pkt_count", W'(pkt_count), W'(pkts_exp));

        // EOP exactly at the length limit is not a truncation.
        send_pkt(MB);
        wait_drain("t4_drain", 50);
        chk("t4_drop_count", W'(drop_count), W'(3));
        chk("t4_trunc_pulses", W'(tp_seen - tp0), W'(1));

        // Clear mid-packet with a full buffer: the next packet restarts at beat 0.
        out_ready = 1'b0;
        pc = int'(pkt_count);
        p0 = pops;
        src_q.push_back({1'b0, rand_pl()});
        src_q.push_back({1'b0, rand_pl()});
        build_pkt(5);
        expect_pkt();
        foreach (pkt[j]) src_q.push_back(pkt[j]);
        repeat (6) step();
        chk("t5_pops_before_clear", W'(pops - p0), W'(2));
        mon_en = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_valid_after_clear", W'(out_valid), W'(0));
        chk("t5_busy_after_clear", W'(busy), W'(0));
        chk("t5_pkt_count_kept", W'(pkt_count), W'(pc));
        mon_en = 1'b1;
        out_ready = 1'b1;
        wait_drain("t5_drain", 50);
        chk("t5_pkt_count", W'(pkt_count), W'(pc + 1));
        chk("t5_drop_count", W'(drop_count), W'(4));

        // Random backpressure and FIFO gaps over a long packet stream.
        words = 0;
        while (words < 10000) begin
            i = $urandom_range(1, 7);
            send_pkt(i);
            words += i;
        end
        i = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && i < 60000) begin
            gate      = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            i++;
        end
        gate      = 1'b0;
        out_ready = 1'b1;
        wait_drain("t6_drain", 200);
        chk("t6_scoreboard_empty", W'(exp_q.size()), W'(0));
        chk("t6_pkt_count", W'(pkt_count), W'(pkts_exp));
        chk("t6_drop_count", W'(drop_count), W'(drops_exp));
        chk("t6_trunc_pulses", W'(tp_seen), W'(truncs_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
